// File: rtl/pc_controller_pkg.sv
// Shared definitions for the fetch-stage PC controller: FSM state encoding,
// default vector addresses and the branch/sequential select helper.
package pc_controller_pkg;

  typedef enum logic [2:0] {
    ST_RST_HI = 3'd0,
    ST_RST_LO = 3'd1,
    ST_RUN    = 3'd2,
    ST_INT_HI = 3'd3,
    ST_INT_LO = 3'd4
  } state_t;

  localparam logic [31:0] DEF_RESET_VEC_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VEC_ADDR   = 32'h0000_0002;

  // Two-input word mux shared by fetch-path blocks: sel=1 picks b.
  function automatic logic [31:0] mux_2x1(input logic sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/pc_controller_program_counter.sv
// Program counter register: loads i_data when enabled, clears on an
// asynchronous active-high reset.
module program_counter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_data,
  output logic [31:0] o_pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc <= '0;
    end else if (i_enable) begin
      o_pc <= i_data;
    end
  end

endmodule

// File: rtl/pc_controller.sv
// Fetch-stage PC sequencer: loads reset/interrupt vectors from instruction
// memory in two 16-bit halves, then steps, holds or redirects the PC.
module pc_controller
  import pc_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VEC_ADDR = DEF_RESET_VEC_ADDR,
  parameter logic [31:0] INT_VEC_ADDR   = DEF_INT_VEC_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_interrupt,
  input  logic [15:0] i_imem_data,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_pc,
  output logic        o_instr_valid,
  output logic        o_int_ack,
  output logic [31:0] o_ret_pc
);

  state_t      state, state_next;
  logic [15:0] vec_hi;
  logic [31:0] ret_pc;
  logic        int_pending;
  logic [31:0] pc, next_pc;
  logic        hold, capture_hi, vec_load, take_int, clear_pending;

  program_counter u_program_counter (
    .i_clk    (i_clk),
    .i_reset  (~i_reset),
    .i_enable (~hold),
    .i_data   (next_pc),
    .o_pc     (pc)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    hold          = 1'b1;
    capture_hi    = 1'b0;
    vec_load      = 1'b0;
    take_int      = 1'b0;
    clear_pending = 1'b0;
    o_imem_addr   = pc;
    o_instr_valid = 1'b0;
    o_int_ack     = 1'b0;
    case (state)
      ST_RST_HI: begin
        o_imem_addr = RESET_VEC_ADDR;
        capture_hi  = 1'b1;
        state_next  = ST_RST_LO;
      end
      ST_RST_LO: begin
        o_imem_addr = RESET_VEC_ADDR + 32'd1;
        vec_load    = 1'b1;
        hold        = 1'b0;
        state_next  = ST_RUN;
      end
      ST_RUN: begin
        o_instr_valid = ~i_stall & ~i_branch_taken;
        if (i_branch_taken) begin
          hold = 1'b0;
        end else if (int_pending && !i_stall) begin
          // Interrupt entry: PC is frozen as the return address, decode gets bubbles.
          take_int      = 1'b1;
          o_instr_valid = 1'b0;
          state_next    = ST_INT_HI;
        end else if (!i_stall) begin
          hold = 1'b0;
        end
      end
      ST_INT_HI: begin
        o_imem_addr = INT_VEC_ADDR;
        capture_hi  = 1'b1;
        state_next  = ST_INT_LO;
      end
      ST_INT_LO: begin
        o_imem_addr   = INT_VEC_ADDR + 32'd1;
        vec_load      = 1'b1;
        hold          = 1'b0;
        clear_pending = 1'b1;
        o_int_ack     = 1'b1;
        state_next    = ST_RUN;
      end
      default: state_next = ST_RST_HI;
    endcase

    next_pc = vec_load ? {vec_hi, i_imem_data}
                       : mux_2x1(i_branch_taken, pc + 32'd1, i_branch_target);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_RST_HI;
      vec_hi      <= '0;
      ret_pc      <= '0;
      int_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (capture_hi) vec_hi <= i_imem_data;
      if (take_int)   ret_pc <= pc;
      // A request arriving in the clearing cycle survives, so back-to-back
      // interrupts are serviced right after returning to RUN.
      int_pending <= i_interrupt | (int_pending & ~clear_pending);
    end
  end

  assign o_pc     = pc;
  assign o_ret_pc = ret_pc;

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pc_controller;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] IV = 32'h0000_0002;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        i_interrupt = 1'b0;
  logic [15:0] i_imem_data;
  logic [31:0] o_imem_addr;
  logic [31:0] o_pc;
  logic        o_instr_valid;
  logic        o_int_ack;
  logic [31:0] o_ret_pc;

  int checks = 0;
  int failures = 0;

  logic [15:0] vec [4];

  pc_controller #(.RESET_VEC_ADDR(RV), .INT_VEC_ADDR(IV)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_interrupt     (i_interrupt),
    .i_imem_data     (i_imem_data),
    .o_imem_addr     (o_imem_addr),
    .o_pc            (o_pc),
    .o_instr_valid   (o_instr_valid),
    .o_int_ack       (o_int_ack),
    .o_ret_pc        (o_ret_pc)
  );

  always #5 i_clk = ~i_clk;

  // Instruction memory: four programmable vector words, a fixed pattern elsewhere.
  always_comb begin
    if (o_imem_addr < 32'd4) i_imem_data = vec[o_imem_addr[1:0]];
    else                     i_imem_data = o_imem_addr[15:0] ^ 16'h5A3C;
  end

  function automatic logic [15:0] imem_read(input logic [31:0] a);
    if (a < 32'd4) return vec[a[1:0]];
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Behavioural model: running PC, or a two-word vector fetch from m_base
  // with m_left words still to read.
  logic [31:0] m_pc, m_ret, m_base;
  logic [15:0] m_hi;
  logic        m_pending;
  int          m_left;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_pc <= '0; m_ret <= '0; m_pending <= 1'b0; m_left <= 2; m_base <= RV; m_hi <= '0;
    end else if (m_left == 0) begin
      if (i_branch_taken) m_pc <= i_branch_target;
      else if (m_pending && !i_stall) begin
        m_ret <= m_pc; m_left <= 2; m_base <= IV;
      end else if (!i_stall) m_pc <= m_pc + 32'd1;
      m_pending <= m_pending | i_interrupt;
    end else if (m_left == 2) begin
      m_hi <= imem_read(m_base);
      m_left <= 1;
      m_pending <= m_pending | i_interrupt;
    end else begin
      m_pc <= {m_hi, imem_read(m_base + 32'd1)};
      m_pending <= (m_base == IV) ? i_interrupt : (m_pending | i_interrupt);
      m_left <= 0;
    end
  end

  always @(negedge i_clk) begin
    logic [31:0] exp_addr;
    logic        exp_ack;
    exp_addr = (m_left == 0) ? m_pc : m_base + ((m_left == 2) ? 32'd0 : 32'd1);
    exp_ack  = (m_left == 1) && (m_base == IV);
    check("model_imem_addr", o_imem_addr, exp_addr);
    check("model_pc", o_pc, m_pc);
    check("model_instr_valid", {31'd0, o_instr_valid},
          {31'd0, (m_left == 0) && !i_stall && !i_branch_taken && !m_pending});
    check("model_int_ack", {31'd0, o_int_ack}, {31'd0, exp_ack});
    if (exp_ack || !i_reset) check("model_ret_pc", o_ret_pc, m_ret);
  end

  initial begin
    vec[0] = 16'h0000; vec[1] = 16'h0010; vec[2] = 16'h0000; vec[3] = 16'h0100;

    step(); step();
    check("rst_pc", o_pc, 32'h0);
    check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("rst_ack", {31'd0, o_int_ack}, 32'd0);
    check("rst_ret_pc", o_ret_pc, 32'h0);
    check("rst_addr", o_imem_addr, RV);

    i_reset = 1'b1;
    step();
    check("rst_lo_addr", o_imem_addr, RV + 32'd1);
    step();
    check("reset_vec_pc", o_pc, 32'h10);
    check("first_valid", {31'd0, o_instr_valid}, 32'd1);

    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", o_pc, 32'h10 + i);
    end

    i_stall = 1'b1;
    #1;
    check("stall_valid", {31'd0, o_instr_valid}, 32'd0);
    step();
    check("stall_hold1", o_pc, 32'h14);
    step();
    check("stall_hold2", o_pc, 32'h14);
    i_branch_taken = 1'b1; i_branch_target = 32'h40;
    step();
    check("branch_in_stall", o_pc, 32'h40);
    i_stall = 1'b0; i_branch_taken = 1'b0;

    i_interrupt = 1'b1;
    step();
    i_interrupt = 1'b0;
    check("int_pc_advanced", o_pc, 32'h41);
    #1;
    check("int_entry_bubble", {31'd0, o_instr_valid}, 32'd0);
    step();
    check("int_hi_addr", o_imem_addr, IV);
    step();
    check("int_lo_addr", o_imem_addr, IV + 32'd1);
    check("int_ack", {31'd0, o_int_ack}, 32'd1);
    check("int_ret_pc", o_ret_pc, 32'h41);
    step();
    check("int_handler_pc", o_pc, 32'h100);
    check("int_ack_pulse", {31'd0, o_int_ack}, 32'd0);

    i_interrupt = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h80;
    step();
    i_interrupt = 1'b0; i_branch_taken = 1'b0;
    check("simul_branch_first", o_pc, 32'h80);
    step(); step();
    check("simul_ack", {31'd0, o_int_ack}, 32'd1);
    check("simul_ret_pc", o_ret_pc, 32'h80);
    step();
    check("simul_handler_pc", o_pc, 32'h100);

    i_branch_taken = 1'b1; i_branch_target = 32'hFFFF_FFFF;
    step();
    i_branch_taken = 1'b0;
    check("wrap_pre", o_pc, 32'hFFFF_FFFF);
    step();
    check("wrap_post", o_pc, 32'h0);

    i_interrupt = 1'b1;
    step();
    i_interrupt = 1'b0;
    step(); step();
    check("abort_in_int_lo", {31'd0, o_int_ack}, 32'd1);
    #2 i_reset = 1'b0;
    #1;
    check("abort_pc", o_pc, 32'h0);
    check("abort_ack", {31'd0, o_int_ack}, 32'd0);
    check("abort_valid", {31'd0, o_instr_valid}, 32'd0);
    check("abort_ret_pc", o_ret_pc, 32'h0);
    check("abort_addr", o_imem_addr, RV);
    step();
    i_reset = 1'b1;
    step(); step();
    check("abort_reload_pc", o_pc, 32'h10);
    check("abort_pending_cleared", {31'd0, o_instr_valid}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      i_stall        = ($urandom_range(0, 99) < 25);
      i_branch_taken = ($urandom_range(0, 99) < 10);
      i_branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2))
                                                    : $urandom;
      i_interrupt    = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 3) vec[$urandom_range(0, 3)] = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 i_reset = 1'b0;
        step();
        i_reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
